// File: rtl/noise_add_if.sv
// Coefficient stream bus for noise_add: INTT input stream and summed output stream.
interface noise_add_if #(
  parameter int unsigned W = 16
);
  logic         in_valid;
  logic [W-1:0] in_coeff;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_coeff;
  logic [1:0]   out_poly_idx;
  logic [7:0]   out_coeff_idx;
  logic         out_last;

  // The noise_add block itself.
  modport master (
    input  in_valid, in_coeff, out_ready,
    output in_ready, out_valid, out_coeff, out_poly_idx, out_coeff_idx, out_last
  );

  // The surrounding datapath: INTT producer and downstream consumer.
  modport slave (
    output in_valid, in_coeff, out_ready,
    input  in_ready, out_valid, out_coeff, out_poly_idx, out_coeff_idx, out_last
  );
endinterface

// File: rtl/noise_add.sv
// noise_add: adds e1 (u polys) and e2 (v' poly) to the streamed INTT coefficients, mod Q.
module noise_add #(
  parameter int unsigned Q = 3329,
  parameter int unsigned N = 256,
  parameter int unsigned K = 3,
  parameter int unsigned W = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          noise_valid,
  input  logic [W-1:0]  e1 [K][N],
  input  logic [W-1:0]  e2 [N],
  noise_add_if.master   bus,
  output logic          done
);

  localparam int unsigned SUM_W = 14;
  localparam int unsigned P_W   = 2;
  localparam int unsigned C_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [P_W-1:0]   p_q, p_d;
  logic [C_W-1:0]   c_q, c_d;
  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     out_coeff_q, out_coeff_d;
  logic [P_W-1:0]   out_poly_q, out_poly_d;
  logic [C_W-1:0]   out_cidx_q, out_cidx_d;
  logic             done_q, done_d;

  logic             in_ready_c;
  logic             accept_c;
  logic             out_fire_c;
  logic             last_c;
  logic [P_W-1:0]   e1_sel_c;
  logic [W-1:0]     noise_c;
  logic [SUM_W-1:0] sum_c;
  logic [SUM_W-1:0] mod_c;

  // Noise operand for the current input position; e1 row index parked at 0 while on the v' poly.
  always_comb begin
    e1_sel_c = (p_q == P_W'(K)) ? '0 : p_q;
    noise_c  = (p_q == P_W'(K)) ? e2[c_q] : e1[e1_sel_c][c_q];
  end

  // Modular add with a single conditional subtract; both operands are canonical.
  always_comb begin
    sum_c = SUM_W'(bus.in_coeff) + SUM_W'(noise_c);
    mod_c = (sum_c >= SUM_W'(Q)) ? (sum_c - SUM_W'(Q)) : sum_c;
  end

  // Handshake qualifiers: the output register acts as a one-entry skid.
  always_comb begin
    in_ready_c = (state_q == RUN) && (!out_valid_q || bus.out_ready);
    accept_c   = in_ready_c && bus.in_valid;
    out_fire_c = out_valid_q && bus.out_ready;
    last_c     = out_valid_q && (out_poly_q == P_W'(K)) && (out_cidx_q == C_W'(N - 1));
  end

  // Next-state, counter and output-register logic.
  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    out_coeff_d = out_coeff_q;
    out_poly_d  = out_poly_q;
    out_cidx_d  = out_cidx_q;
    done_d      = done_q;

    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (noise_valid) begin
          state_d = RUN;
        end
      end

      RUN: begin
        if (out_fire_c) begin
          out_valid_d = 1'b0;
        end
        if (accept_c) begin
          out_valid_d = 1'b1;
          out_coeff_d = W'(mod_c);
          out_poly_d  = p_q;
          out_cidx_d  = c_q;
          if (c_q == C_W'(N - 1)) begin
            c_d = '0;
            if (p_q == P_W'(K)) begin
              state_d = DRAIN;
            end else begin
              p_d = p_q + P_W'(1);
            end
          end else begin
            c_d = c_q + C_W'(1);
          end
        end
      end

      DRAIN: begin
        if (out_fire_c) begin
          out_valid_d = 1'b0;
          if (last_c) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end

      DONE: begin
        out_valid_d = 1'b0;
        done_d      = 1'b1;
        if (!noise_valid) begin
          state_d = IDLE;
          done_d  = 1'b0;
          p_d     = '0;
          c_d     = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      p_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      out_coeff_q <= '0;
      out_poly_q  <= '0;
      out_cidx_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      out_coeff_q <= out_coeff_d;
      out_poly_q  <= out_poly_d;
      out_cidx_q  <= out_cidx_d;
      done_q      <= done_d;
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_coeff     = out_coeff_q;
  assign bus.out_poly_idx  = out_poly_q;
  assign bus.out_coeff_idx = out_cidx_q;
  assign bus.out_last      = last_c;
  assign done              = done_q;

endmodule

// File: tb/tb_noise_add.sv
// Directed bench for noise_add: reset, mod-Q wrap, full-rate streaming, backpressure, restart.
module tb_noise_add;

  localparam int unsigned Q = 3329;
  localparam int unsigned N = 256;
  localparam int unsigned K = 3;
  localparam int unsigned W = 16;
  localparam int TOTAL = 1024;

  logic         clk;
  logic         rst;
  logic         noise_valid;
  logic [W-1:0] e1 [K][N];
  logic [W-1:0] e2 [N];
  logic         done;

  noise_add_if #(.W(W)) bus ();

  noise_add #(.Q(Q), .N(N), .K(K), .W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .noise_valid (noise_valid),
    .e1          (e1),
    .e2          (e2),
    .bus         (bus),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int in_data  [TOTAL];
  int exp_data [TOTAL];
  int obs      [TOTAL];

  // Single comparison point: counts, and reports any mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Reference sums straight from the definition (a + e) mod Q.
  task automatic compute_exp();
    for (int k = 0; k < TOTAL; k++) begin
      int p, c, n;
      p = k / N;
      c = k % N;
      n = (p < K) ? int'(e1[p][c]) : int'(e2[c]);
      exp_data[k] = (in_data[k] + n) % Q;
    end
  endtask

  task automatic fill_random();
    for (int p = 0; p < K; p++)
      for (int c = 0; c < N; c++) e1[p][c] = W'($urandom_range(Q - 1));
    for (int c = 0; c < N; c++) e2[c] = W'($urandom_range(Q - 1));
    for (int k = 0; k < TOTAL; k++) in_data[k] = $urandom_range(Q - 1);
  endtask

  // Drive a full vector and score every output handshake in order.
  task automatic run_stream(input int vpct, input int rpct, input bit check_rate);
    int in_n, out_n, cyc, first_cyc, last_cyc;
    bit held;
    logic [W-1:0] held_v;
    logic [26:0] got_v, exp_v;
    in_n = 0; out_n = 0; cyc = 0; first_cyc = -1; last_cyc = 0;
    held = 1'b0; held_v = '0;
    while (out_n < TOTAL && cyc < 20000) begin
      bus.in_valid  = (in_n < TOTAL) && ($urandom_range(99) < vpct);
      bus.in_coeff  = (in_n < TOTAL) ? W'(in_data[in_n]) : '0;
      bus.out_ready = ($urandom_range(99) < rpct);
      #1;
      if (held) check("stall_hold", 32'(bus.out_coeff), 32'(held_v));
      if (bus.in_valid && bus.in_ready) in_n++;
      if (bus.out_valid && bus.out_ready) begin
        got_v = {bus.out_last, bus.out_poly_idx, bus.out_coeff_idx, bus.out_coeff};
        exp_v = {(out_n == TOTAL - 1), 2'(out_n / N), 8'(out_n % N), 16'(exp_data[out_n])};
        check($sformatf("out[%0d]", out_n), 32'(got_v), 32'(exp_v));
        obs[out_n] = int'(bus.out_coeff);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        out_n++;
        held = 1'b0;
      end else begin
        held   = bus.out_valid;
        held_v = bus.out_coeff;
      end
      @(posedge clk);
      #2;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("stream_complete", 32'(out_n), 32'(TOTAL));
    if (check_rate) check("full_rate_span", 32'(last_cyc - first_cyc), 32'(TOTAL - 1));
    check("done_after_last", 32'(done), 32'd1);
  endtask

  // Done holds while noise_valid stays high, then clears once it drops.
  task automatic finish_vector();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("done_hold", 32'({done, bus.in_ready, bus.out_valid}), 32'b100);
    end
    noise_valid = 1'b0;
    tick();
    check("done_clear", 32'({done, bus.in_ready}), 32'b00);
  endtask

  initial begin
    rst           = 1'b1;
    noise_valid   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_coeff  = '0;
    bus.out_ready = 1'b0;
    for (int p = 0; p < K; p++)
      for (int c = 0; c < N; c++) e1[p][c] = '0;
    for (int c = 0; c < N; c++) e2[c] = '0;

    // Reset values.
    repeat (3) tick();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_coeff", 32'(bus.out_coeff), 32'd0);
    check("rst_idx", 32'({bus.out_poly_idx, bus.out_coeff_idx}), 32'd0);
    check("rst_last_done_ready", 32'({bus.out_last, done, bus.in_ready}), 32'd0);
    rst = 1'b0;
    tick();
    check("idle_no_ready", 32'(bus.in_ready), 32'd0);

    // Full-rate streaming: e = 1 everywhere, in = index, so out = index + 1.
    for (int p = 0; p < K; p++)
      for (int c = 0; c < N; c++) e1[p][c] = 16'd1;
    for (int c = 0; c < N; c++) e2[c] = 16'd1;
    for (int k = 0; k < TOTAL; k++) in_data[k] = k;
    compute_exp();
    noise_valid = 1'b1;
    run_stream(100, 100, 1'b1);
    check("stream_first", 32'(obs[0]), 32'd1);
    check("stream_v_last", 32'(obs[TOTAL - 1]), 32'd1024);
    finish_vector();

    // Wrap boundaries under random backpressure with random canonical data.
    fill_random();
    e1[0][0] = 16'd2;    in_data[0] = 3328;
    e1[0][1] = 16'd3327; in_data[1] = 2;
    e1[0][2] = 16'd0;    in_data[2] = 3328;
    e2[N-1]  = 16'd3328; in_data[TOTAL - 1] = 3328;
    compute_exp();
    noise_valid = 1'b1;
    run_stream(70, 50, 1'b0);
    check("wrap_3328_plus_2", 32'(obs[0]), 32'd1);
    check("wrap_2_plus_3327", 32'(obs[1]), 32'd0);
    check("wrap_3328_plus_0", 32'(obs[2]), 32'd3328);
    check("wrap_v_max", 32'(obs[TOTAL - 1]), 32'd3327);
    finish_vector();

    // Reset after 100 accepts, then a clean run must restart at poly 0 coeff 0.
    fill_random();
    compute_exp();
    noise_valid = 1'b1;
    begin
      int acc, cyc;
      acc = 0; cyc = 0;
      while (acc < 100 && cyc < 2000) begin
        bus.in_valid  = 1'b1;
        bus.in_coeff  = W'(in_data[acc]);
        bus.out_ready = 1'b1;
        #1;
        if (bus.in_ready) acc++;
        @(posedge clk);
        #2;
        cyc++;
      end
      check("pre_reset_accepts", 32'(acc), 32'd100);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("midrun_rst_valid_last", 32'({bus.out_valid, bus.out_last, done}), 32'd0);
    check("midrun_rst_coeff", 32'(bus.out_coeff), 32'd0);
    check("midrun_rst_idx", 32'({bus.out_poly_idx, bus.out_coeff_idx}), 32'd0);
    check("midrun_rst_ready", 32'(bus.in_ready), 32'd0);
    repeat (2) tick();
    rst = 1'b0;
    run_stream(80, 60, 1'b0);
    finish_vector();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/noise_add.md
Name: noise_add

Overview:
- Downstream consumer of noise_gen.
- Adds the sampled error polynomials e1 (K polys) and e2 (1 poly) coefficient-wise, mod q, to the inverse-NTT results streamed in by the encryption datapath.
- Produces u = INTT(A^T·r̂) + e1 and v' = INTT(t^T·r̂) + e2 as one output coefficient stream.
- Reads noise_gen's parallel r/e1/e2 arrays directly; the message term is added later by a separate stage.

Parameters:
- Q, 3329, Kyber modulus.
- N, 256, coefficients per polynomial.
- K, 3, module rank (Kyber768).
- W, 16, coefficient storage width.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- noise_valid  input  1  level; high while e1/e2 are stable (driven from noise_gen noise_done).
- e1  input  [W-1:0] x [0:K-1][0:N-1]  error vector e1, canonical in [0,Q-1].
- e2  input  [W-1:0] x [0:N-1]  error poly e2, canonical in [0,Q-1].
- in_valid  input  1  in_coeff is valid.
- in_coeff  input  W  INTT coefficient, canonical in [0,Q-1].
- in_ready  output  1  block accepts in_coeff this cycle.
- out_valid  output  1  out_coeff is valid.
- out_ready  input  1  downstream accepts out_coeff.
- out_coeff  output  W  sum mod Q.
- out_poly_idx  output  2  0..K-1 selects u[i]; K selects v'.
- out_coeff_idx  output  8  coefficient index 0..N-1.
- out_last  output  1  high with the final coefficient (poly K, index N-1).
- done  output  1  whole vector emitted.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; counters=0; in_ready=0, out_valid=0, out_coeff=0, out_poly_idx=0, out_coeff_idx=0, out_last=0, done=0.
  - Reset takes priority over every other event, including mid-stream; any partial output is discarded.
- Input order: poly 0 coeff 0..N-1, poly 1, ..., poly K-1 (u path), then poly K (v path). Total (K+1)·N = 1024 coefficients.
- Operand selection: p<K uses e1[p][c]; p==K uses e2[c]. p = input poly counter, c = input coeff counter.
- Arithmetic:
  - s = in_coeff + noise, computed 14 bits wide.
  - out = (s >= Q) ? s-Q : s, a single conditional subtract.
  - Operands in [0,Q-1] are a precondition; out-of-range operands give undefined results.
- FSM states:
  - IDLE: in_ready=0. Goes to RUN when noise_valid=1.
  - RUN: in_ready = !out_valid || out_ready.
    - Each accept (in_valid && in_ready) registers the result with one-cycle latency: out_valid=1 next cycle, with out_poly_idx/out_coeff_idx = (p,c) of the accepted input.
    - c increments and wraps N-1 -> 0, incrementing p.
    - After accepting p==K, c==N-1, in_ready drops to 0 and the FSM goes to DRAIN.
  - DRAIN: waits for the last output handshake (out_valid && out_ready with out_last=1), then goes to DONE.
  - DONE: done=1, out_valid=0. Stays until noise_valid=0, then goes to IDLE with done=0 and counters cleared.
- Output register is a one-entry skid:
  - It holds its value while out_valid && !out_ready.
  - An output handshake and a new accept in the same cycle load the new value, so throughput is 1 coeff/cycle.
- noise_valid falling during RUN/DRAIN is ignored; the vector completes. e1/e2 must remain stable until done.
- out_last = out_valid && out_poly_idx==K && out_coeff_idx==N-1.

Test Plan:
- Reset: hold rst 3 cycles mid-RUN after 100 accepts -> all outputs 0 next cycle, state IDLE; new run restarts at poly 0 coeff 0.
- Wrap boundary: e1[0][0]=2, in_coeff=3328 -> out_coeff=1. Also e1[0][1]=3327, in_coeff=2 -> 0; e1[0][2]=0, in_coeff=3328 -> 3328.
- Streaming: e1=e2=all 1, in_coeff=index mod 3329, in_valid always 1, out_ready always 1 -> 1024 outputs on consecutive cycles.
  - out_coeff = in+1; poly idx advances every 256 outputs; out_last on output 1023; done 1 cycle after.
- Backpressure: random out_ready (50%), random in_valid gaps -> no lost or duplicated coefficients; out_coeff stable while stalled; order matches the golden model.
- Golden: feed noise_gen outputs for coin f8f11229...5598 plus random canonical in_coeff -> match a software (a+e) mod 3329 model for u[0..2] and v'.
- Handshake end: keep noise_valid=1 after done -> done stays 1, in_ready=0. Drop noise_valid -> IDLE next cycle, done=0; re-raise -> second run correct.
